nibble_serial_subtractor: RTL and testbench

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

---
 rtl/nibble_serial_subtractor.sv | 124 ++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: one 4-bit slice per cycle, LSB nibble first, with registered flags.
// Optional add/subtract mode port and behaviour are enabled by defining ADD_MODE_EN.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ADD_MODE_EN
  input  logic             mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             add_q;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       sum;
  logic [WIDTH-1:0] diff_next;
  logic             ovf_next;

`ifdef ADD_MODE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      add_q <= 1'b0;
    end else if (state == IDLE && start) begin
      add_q <= mode;
    end
  end
`else
  assign add_q = 1'b0;
`endif

  // One slice of the ripple: subtraction is a + ~b with the carry seeded to 1.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    a_nib     = a_q[{idx, 2'b00} +: 4];
    b_nib     = add_q ? b_q[{idx, 2'b00} +: 4] : ~b_q[{idx, 2'b00} +: 4];
    sum       = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    diff_next = diff;
    diff_next[{idx, 2'b00} +: 4] = sum[3:0];
    ovf_next  = (add_q ? (a_q[WIDTH-1] == b_q[WIDTH-1])
                       : (a_q[WIDTH-1] != b_q[WIDTH-1]))
                && (sum[3] != a_q[WIDTH-1]);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
`ifdef ADD_MODE_EN
            carry <= ~mode;
`else
            carry <= 1'b1;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          diff  <= diff_next;
          carry <= sum[4];
          idx   <= idx + IDX_W'(1);
          // Flags are only published together with the final slice.
          if (idx == LAST_IDX) begin
            borrow <= add_q ? sum[4] : ~sum[4];
            ovf    <= ovf_next;
            zero   <= (diff_next == '0);
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (WIDTH=16): stimulus pushes model results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_nibble_serial_subtractor;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;
`ifdef ADD_MODE_EN
  localparam bit HAS_ADD = 1'b1;
`else
  localparam bit HAS_ADD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
`ifdef ADD_MODE_EN
    .mode   (mode),
`endif
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;
    int               due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic m, input int due);
    exp_t e;
    int   sx, sy, r;
    logic [WIDTH:0] wide;
    sx = $signed(x);
    sy = $signed(y);
    if (m) begin
      wide     = {1'b0, x} + {1'b0, y};
      e.diff   = wide[WIDTH-1:0];
      e.borrow = wide[WIDTH];
      r        = sx + sy;
    end else begin
      e.diff   = x - y;
      e.borrow = (x < y);
      r        = sx - sy;
    end
    e.ovf  = (r > 32767) || (r < -32768);
    e.zero = (e.diff == '0);
    e.due  = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("diff",    diff,   mon_e.diff);
        check("borrow",  borrow, mon_e.borrow);
        check("ovf",     ovf,    mon_e.ovf);
        check("zero",    zero,   mon_e.zero);
        check("latency", cyc,    mon_e.due);
        check("busy_at_done", busy, 1);
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic m, input bit push);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    mode  = m;
    if (push) sbq.push_back(model(x, y, m, cyc + N + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_diff",   diff,   0);
    check("rst_borrow", borrow, 0);
    check("rst_ovf",    ovf,    0);
    check("rst_zero",   zero,   0);
    rst = 1'b0;

    issue(16'h1234, 16'h0234, 1'b0, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    check("hold_diff", diff, 16'h1000);
    check("idle_busy", busy, 0);
    check("done_pulse_len", done, 0);

    issue(16'h0000, 16'h0001, 1'b0, 1'b1);
    wait_done();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done();
    issue(16'h5A5A, 16'h5A5A, 1'b0, 1'b1);
    wait_done();

    // Re-pulse start mid-operation with different operands.
    issue(16'h1111, 16'h0222, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);

    // Back-to-back: start in the first idle cycle after done.
    issue(16'h7000, 16'h9000, 1'b0, 1'b1);
    wait_done();
    issue(16'h0F0F, 16'hF0F0, 1'b0, 1'b1);
    wait_done();

    // Abort with reset in the third RUN cycle.
    issue(16'hABCD, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",   busy,   0);
    check("abort_done",   done,   0);
    check("abort_diff",   diff,   0);
    check("abort_borrow", borrow, 0);
    check("abort_ovf",    ovf,    0);
    check("abort_zero",   zero,   0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_idle", busy, 0);

    if (HAS_ADD) begin
      issue(16'hFFFF, 16'h0001, 1'b1, 1'b1);
      wait_done();
      issue(16'h7FFF, 16'h0001, 1'b1, 1'b1);
      wait_done();
      issue(16'h1234, 16'h0234, 1'b0, 1'b1);
      wait_done();
    end

    for (int i = 0; i < 30; i++) begin
      logic [WIDTH-1:0] rx, ry;
      logic             rm;
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      if (i % 7 == 0) ry = rx;
      rm = HAS_ADD ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(rx, ry, rm, 1'b1);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (8) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
